// File: rtl/trdb_stream_packer.sv
// Byte-exact trace packer: optional length header plus payload bytes are appended
// to a byte buffer and drained as OUT_W-bit words, with backpressure and flush.
module trdb_stream_packer #(
    parameter int unsigned PACKET_LEN = 72,
    parameter int unsigned LEN_W      = 7,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned HEADER_EN  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PACKET_LEN-1:0] packet_bits_i,
    input  logic [LEN_W-1:0]      packet_len_i,
    input  logic                  valid_i,
    output logic                  grant_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [OUT_W-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned OB        = OUT_W / 8;
    localparam int unsigned PB_MAX    = (PACKET_LEN + 7) / 8;
    localparam int unsigned INS_BYTES = PB_MAX + HEADER_EN;
    localparam int unsigned BUF_BYTES = OB - 1 + INS_BYTES;
    localparam int unsigned BUF_W     = BUF_BYTES * 8;
    localparam int unsigned INS_W     = INS_BYTES * 8;
    localparam int unsigned FILL_W    = $clog2(BUF_BYTES + 1);
    localparam logic [FILL_W-1:0] OB_F = FILL_W'(OB);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;

    logic [PACKET_LEN-1:0] payload_masked;
    logic [LEN_W:0]        len_round;
    logic [7:0]            pb;
    logic [INS_W-1:0]      ins_bytes;
    logic [BUF_W-1:0]      ins_ext;
    logic                  pop;

    // Zeroing every bit at or above len keeps unused buffer bytes at zero,
    // so the new packet can simply be OR-ed in above the current fill.
    always_comb begin
        for (int unsigned i = 0; i < PACKET_LEN; i++) begin
            payload_masked[i] = packet_bits_i[i] & (i < 32'(packet_len_i));
        end
        len_round = {1'b0, packet_len_i} + (LEN_W + 1)'(7);
        pb        = 8'(len_round >> 3);
        if (HEADER_EN != 0) begin
            ins_bytes = INS_W'({(PB_MAX * 8)'(payload_masked), pb});
        end else begin
            ins_bytes = INS_W'(payload_masked);
        end
        ins_ext = BUF_W'(ins_bytes);
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        fill_d       = fill_q;
        grant_o      = 1'b0;
        valid_o      = 1'b0;
        flush_done_o = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                grant_o = valid_i & ~flush_i & (fill_q < OB_F);
                valid_o = (fill_q >= OB_F);
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                valid_o = (fill_q != '0);
                if (fill_q == '0) begin
                    state_d = ST_DONE;
                end else if (ready_i && (fill_q <= OB_F)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        pop = valid_o & ready_i;
        if (grant_o) begin
            buf_d  = buf_q | (ins_ext << {fill_q, 3'b000});
            fill_d = fill_q + FILL_W'(pb) + FILL_W'(HEADER_EN);
        end else if (pop) begin
            buf_d  = buf_q >> OUT_W;
            fill_d = (fill_q > OB_F) ? (fill_q - OB_F) : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    assign data_o = buf_q[OUT_W-1:0];

    a_len_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_i |-> (packet_len_i <= LEN_W'(PACKET_LEN)));

endmodule

// File: tb/tb_trdb_stream_packer.sv
// Bench for trdb_stream_packer: a 32-bit/header instance and a 64-bit/raw instance,
// checked against a byte-stream scoreboard plus directed timing checks.
module tb_trdb_stream_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [71:0] bits_a, bits_b;
    logic [6:0]  len_a, len_b;
    logic        valid_a, valid_b, flush_a, flush_b, ready_a, ready_b;
    logic        grant_a, grant_b, done_a, done_b, vo_a, vo_b;
    logic [31:0] data_a;
    logic [63:0] data_b;

    trdb_stream_packer #(.PACKET_LEN(72), .LEN_W(7), .OUT_W(32), .HEADER_EN(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .packet_bits_i(bits_a), .packet_len_i(len_a),
        .valid_i(valid_a), .grant_o(grant_a), .flush_i(flush_a), .flush_done_o(done_a),
        .data_o(data_a), .valid_o(vo_a), .ready_i(ready_a));

    trdb_stream_packer #(.PACKET_LEN(72), .LEN_W(7), .OUT_W(64), .HEADER_EN(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .packet_bits_i(bits_b), .packet_len_i(len_b),
        .valid_i(valid_b), .grant_o(grant_b), .flush_i(flush_b), .flush_done_o(done_b),
        .data_o(data_b), .valid_o(vo_b), .ready_i(ready_b));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    byte unsigned mb_a[$], mb_b[$];
    logic [63:0]  ew_a[$], ew_b[$];

    task automatic model_drain(input bit sel, input bit flush);
        logic [63:0] w;
        if (sel) begin
            while (mb_b.size() >= 8 || (flush && mb_b.size() > 0)) begin
                w = '0;
                for (int i = 0; i < 8 && mb_b.size() > 0; i++) w[8*i +: 8] = mb_b.pop_front();
                ew_b.push_back(w);
            end
        end else begin
            while (mb_a.size() >= 4 || (flush && mb_a.size() > 0)) begin
                w = '0;
                for (int i = 0; i < 4 && mb_a.size() > 0; i++) w[8*i +: 8] = mb_a.pop_front();
                ew_a.push_back(w);
            end
        end
    endtask

    task automatic model_pkt(input bit sel, input logic [71:0] bits, input int unsigned len);
        byte unsigned nb[$];
        int unsigned  pb = (len + 7) / 8;
        logic [7:0]   b;
        if (!sel) nb.push_back(8'(pb));
        for (int k = 0; k < int'(pb); k++) begin
            for (int j = 0; j < 8; j++) b[j] = (8 * k + j < int'(len)) ? bits[8*k+j] : 1'b0;
            nb.push_back(b);
        end
        foreach (nb[i]) begin
            if (sel) mb_b.push_back(nb[i]);
            else     mb_a.push_back(nb[i]);
        end
        model_drain(sel, 1'b0);
    endtask

    // Scoreboard pop on every handshake; A also checks that a stalled word holds.
    logic        stall_a;
    logic [31:0] hold_a;
    always @(negedge clk) begin
        if (rst) begin
            stall_a <= 1'b0;
        end else begin
            if (stall_a) begin
                check("a_stall_valid", vo_a, 1);
                check("a_stall_data", data_a, hold_a);
                check("a_stall_grant", grant_a, 0);
            end
            if (vo_a && ready_a) begin
                if (ew_a.size() == 0) check("a_spurious", vo_a, 0);
                else                  check("a_word", data_a, ew_a.pop_front());
            end
            stall_a <= vo_a & ~ready_a;
            hold_a  <= data_a;
        end
    end

    always @(negedge clk) begin
        if (!rst && vo_b && ready_b) begin
            if (ew_b.size() == 0) check("b_spurious", vo_b, 0);
            else                  check("b_word", data_b, ew_b.pop_front());
        end
    end

    task automatic send(input bit sel, input logic [71:0] bits, input int unsigned len);
        int unsigned n = 0;
        if (sel) begin bits_b = bits; len_b = 7'(len); valid_b = 1'b1; end
        else     begin bits_a = bits; len_a = 7'(len); valid_a = 1'b1; end
        @(negedge clk);
        while (!(sel ? grant_b : grant_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "b_grant_wait" : "a_grant_wait", sel ? grant_b : grant_a, 1);
        if (sel ? grant_b : grant_a) model_pkt(sel, bits, len);
        @(posedge clk); #2;
        if (sel) valid_b = 1'b0;
        else     valid_a = 1'b0;
    endtask

    task automatic do_flush(input bit sel);
        int unsigned n = 0;
        if (sel) flush_b = 1'b1;
        else     flush_a = 1'b1;
        model_drain(sel, 1'b1);
        @(posedge clk); #2;
        flush_a = 1'b0;
        flush_b = 1'b0;
        @(negedge clk);
        while (!(sel ? done_b : done_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "b_flush_done" : "a_flush_done", sel ? done_b : done_a, 1);
        @(negedge clk);
        check(sel ? "b_flush_pulse" : "a_flush_pulse", sel ? done_b : done_a, 0);
        @(posedge clk); #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    bit stop;

    initial begin
        rst = 1'b1;
        bits_a = '0; len_a = '0; valid_a = 0; flush_a = 0; ready_a = 1;
        bits_b = '0; len_b = '0; valid_b = 0; flush_b = 0; ready_b = 1;
        repeat (2) @(negedge clk);
        check("rst_valid_a", vo_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_valid_b", vo_b, 0);
        check("rst_data_b", data_b, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Single packet, garbage above len must be dropped
        bits_a = 72'hFFFFFFFFFFFF5ABCDE; len_a = 7'd20; valid_a = 1'b1;
        @(negedge clk);
        check("t1_grant", grant_a, 1);
        model_pkt(1'b0, bits_a, 20);
        @(posedge clk); #2;
        valid_a = 1'b0;
        @(negedge clk);
        check("t1_valid", vo_a, 1);
        check("t1_data", data_a, 32'h0ABCDE03);
        @(posedge clk); #2;

        // Two 12-bit packets then a flush of the residual bytes
        send(1'b0, 72'h123, 12);
        send(1'b0, 72'h456, 12);
        @(negedge clk);
        check("t2_valid0", vo_a, 1);
        check("t2_word0", data_a, 32'h02012302);
        @(posedge clk); #2;
        flush_a = 1'b1;
        model_drain(1'b0, 1'b1);
        @(negedge clk);
        check("t2_done_c0", done_a, 0);
        @(posedge clk); #2;
        flush_a = 1'b0;
        @(negedge clk);
        check("t2_fvalid", vo_a, 1);
        check("t2_fdata", data_a, 32'h00000456);
        @(posedge clk); #2;
        @(negedge clk);
        check("t2_done", done_a, 1);
        @(posedge clk); #2;
        @(negedge clk);
        check("t2_done_once", done_a, 0);
        @(posedge clk); #2;

        // Backpressure with a second packet waiting
        ready_a = 1'b0;
        bits_a = 72'hABCDE; len_a = 7'd20; valid_a = 1'b1;
        @(negedge clk);
        check("t3_grant0", grant_a, 1);
        model_pkt(1'b0, bits_a, 20);
        @(posedge clk); #2;
        bits_a = 72'h777; len_a = 7'd12;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_grant", grant_a, 0);
            check("t3_valid", vo_a, 1);
            check("t3_data", data_a, 32'h0ABCDE03);
            @(posedge clk); #2;
        end
        ready_a = 1'b1;
        @(negedge clk);
        check("t3_grant_rise", grant_a, 0);
        @(posedge clk); #2;
        @(negedge clk);
        check("t3_grant_next", grant_a, 1);
        if (grant_a) model_pkt(1'b0, 72'h777, 12);
        @(posedge clk); #2;
        valid_a = 1'b0;
        do_flush(1'b0);

        // Empty flush, with a packet offered in the same cycle
        flush_a = 1'b1; valid_a = 1'b1; bits_a = 72'h99; len_a = 7'd8;
        @(negedge clk);
        check("t4_grant", grant_a, 0);
        check("t4_done_c0", done_a, 0);
        @(posedge clk); #2;
        flush_a = 1'b0; valid_a = 1'b0;
        @(negedge clk);
        check("t4_done_c1", done_a, 0);
        check("t4_valid_c1", vo_a, 0);
        @(posedge clk); #2;
        @(negedge clk);
        check("t4_done_c2", done_a, 1);
        @(posedge clk); #2;
        @(negedge clk);
        check("t4_done_c3", done_a, 0);
        @(posedge clk); #2;

        // Reset with residual bytes, then a flush must emit nothing
        send(1'b0, 72'h5A, 8);
        #1 rst = 1'b1;
        #1;
        check("t5_valid", vo_a, 0);
        check("t5_data", data_a, 0);
        mb_a.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        do_flush(1'b0);

        // Length corner cases
        send(1'b0, 72'hFF, 0);
        send(1'b0, 72'hFF, 1);
        send(1'b0, '1, 72);
        send(1'b0, 72'hFF, 0);
        send(1'b0, 72'hFFFF, 9);

        // Random packets under random backpressure
        stop = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    send(1'b0, 72'({$urandom, $urandom, $urandom}), $urandom_range(0, 72));
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    ready_a = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #2;
                end
            end
        join
        ready_a = 1'b1;
        do_flush(1'b0);

        // Wide raw instance: nine single-byte packets
        for (int i = 1; i <= 9; i++) begin
            send(1'b1, 72'(i), 8);
            if (i == 8) begin
                @(negedge clk);
                check("t6_valid", vo_b, 1);
                check("t6_word", data_b, 64'h0807060504030201);
                @(posedge clk); #2;
            end
        end
        do_flush(1'b1);
        send(1'b1, 72'hFF, 0);
        do_flush(1'b1);

        check("a_leftover", ew_a.size(), 0);
        check("b_leftover", ew_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
